// File: rtl/fan_ctrl_pkg.sv
// Shared constants, register map, FSM encoding and duty-adjust arithmetic for fan_ctrl.
package fan_ctrl_pkg;

    localparam logic [4:0] BASE_ADDR  = 5'h18;
    localparam logic [7:0] DUTY_MIN   = 8'd40;
    localparam logic [1:0] SPINUP_WIN = 2'd2;
    localparam logic [1:0] STALL_WIN  = 2'd3;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_TARGET = 2'd1;
    localparam logic [1:0] REG_TACH   = 2'd2;
    localparam logic [1:0] REG_DUTY   = 2'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_AUTO_BIT   = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;
    localparam int CTRL_STALL_BIT  = 7;

    localparam logic [9:0] STEP_BIG   = 10'd8;
    localparam logic [9:0] STEP_SMALL = 10'd1;
    localparam logic [8:0] ERR_THRESH = 9'd16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SPINUP = 2'd1,
        ST_ADJUST = 2'd2
    } fan_state_e;

    // One closed-loop step: move duty toward target by 8 or 1, clamped to [DUTY_MIN, 255].
    function automatic logic [7:0] adj_duty(input logic [7:0] duty,
                                            input logic [7:0] target,
                                            input logic [7:0] tach);
        logic [8:0] err;
        logic [8:0] mag;
        logic [9:0] step;
        logic [9:0] res;
        err  = {1'b0, target} - {1'b0, tach};
        mag  = err[8] ? (9'd0 - err) : err;
        step = (mag >= ERR_THRESH) ? STEP_BIG : STEP_SMALL;
        if (err == 9'd0) begin
            res = {2'b00, duty};
        end else if (!err[8]) begin
            res = {2'b00, duty} + step;
        end else begin
            res = {2'b00, duty} - step;
        end
        // bit 9 set means the subtraction went below zero
        if (res[9]) begin
            adj_duty = DUTY_MIN;
        end else if (res > 10'd255) begin
            adj_duty = 8'hFF;
        end else if (res < {2'b00, DUTY_MIN}) begin
            adj_duty = DUTY_MIN;
        end else begin
            adj_duty = res[7:0];
        end
    endfunction

endpackage

// File: rtl/fan_tach_cnt.sv
// Tachometer front end: 2-flop synchronizer, rising-edge detect and saturating per-window counter.
module fan_tach_cnt
    import fan_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       win_ce,
    input  logic       tach,
    output logic [7:0] cnt,
    output logic       upd
);

    logic       s1_r;
    logic       s2_r;
    logic       prev_r;
    logic [7:0] win_cnt_r;
    logic [7:0] cnt_r;
    logic       upd_r;
    logic       rise_s;

    assign rise_s = s2_r & ~prev_r;

    // Synchronize, detect edges, count within the window and latch at the window strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r      <= 1'b0;
            s2_r      <= 1'b0;
            prev_r    <= 1'b0;
            win_cnt_r <= 8'd0;
            cnt_r     <= 8'd0;
            upd_r     <= 1'b0;
        end else begin
            s1_r   <= tach;
            s2_r   <= s1_r;
            prev_r <= s2_r;
            upd_r  <= win_ce;
            if (win_ce) begin
                cnt_r     <= win_cnt_r;
                // an edge on the strobe cycle belongs to the new window
                win_cnt_r <= rise_s ? 8'd1 : 8'd0;
            end else if (rise_s && (win_cnt_r != 8'hFF)) begin
                win_cnt_r <= win_cnt_r + 8'd1;
            end
        end
    end

    assign cnt = cnt_r;
    assign upd = upd_r;

endmodule

// File: rtl/fan_ctrl.sv
// Closed-loop fan controller with CSR interface. Stall detection is compiled in with FAN_CTRL_STALL_EN.
module fan_ctrl
    import fan_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       win_ce,
    input  logic       tach,
    input  logic [4:0] csr_a,
    input  logic [7:0] csr_di,
    input  logic       csr_we,
    output logic [7:0] csr_do,
    output logic [7:0] pwm_duty,
    output logic       pwm_en,
    output logic       irq
);

    logic [4:0] off_s;
    logic       hit_s;
    logic       wr_ctrl_s;
    logic       wr_target_s;
    logic       wr_duty_s;
    logic       en_r;
    logic       auto_r;
    logic       irq_en_r;
    logic [7:0] target_r;
    logic [7:0] duty_r;
    logic [7:0] duty_nxt_s;
    logic [1:0] spin_r;
    logic [7:0] csr_do_r;
    logic [7:0] rd_data_s;
    logic [7:0] tach_s;
    logic       upd_s;
    logic       auto_rise_s;
    logic       auto_clr_s;
    logic       adjust_s;
    logic       stall_hit_s;
    logic       stall_bit_s;
    fan_state_e state_r;
    fan_state_e state_nxt_s;

    assign off_s       = csr_a - BASE_ADDR;
    assign hit_s       = (off_s < 5'd4);
    assign wr_ctrl_s   = csr_we & hit_s & (off_s[1:0] == REG_CTRL);
    assign wr_target_s = csr_we & hit_s & (off_s[1:0] == REG_TARGET);
    assign wr_duty_s   = csr_we & hit_s & (off_s[1:0] == REG_DUTY);

    assign auto_rise_s = wr_ctrl_s & csr_di[CTRL_AUTO_BIT] & ~auto_r;
    assign auto_clr_s  = wr_ctrl_s & ~csr_di[CTRL_AUTO_BIT];
    assign adjust_s    = (state_r == ST_ADJUST) & upd_s & ~auto_clr_s;

    fan_tach_cnt u_tach (
        .clk    (clk),
        .rst_n  (rst_n),
        .win_ce (win_ce),
        .tach   (tach),
        .cnt    (tach_s),
        .upd    (upd_s)
    );

`ifdef FAN_CTRL_STALL_EN
    logic [1:0] stall_cnt_r;
    logic       stall_r;
    logic       stall_nxt_s;
    logic       irq_en_nxt_s;
    logic       irq_r;

    assign stall_hit_s  = adjust_s & (tach_s == 8'd0) & (stall_cnt_r == (STALL_WIN - 2'd1));
    // a stall being declared outranks a same-cycle write-1-to-clear
    assign stall_nxt_s  = stall_hit_s ? 1'b1 :
                          (wr_ctrl_s & csr_di[CTRL_STALL_BIT]) ? 1'b0 : stall_r;
    assign irq_en_nxt_s = wr_ctrl_s ? csr_di[CTRL_IRQ_EN_BIT] : irq_en_r;

    // Zero-count window tracking, sticky stall flag and its interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 2'd0;
            stall_r     <= 1'b0;
            irq_r       <= 1'b0;
        end else begin
            if (adjust_s) begin
                stall_cnt_r <= ((tach_s != 8'd0) || stall_hit_s) ? 2'd0 : stall_cnt_r + 2'd1;
            end
            stall_r <= stall_nxt_s;
            irq_r   <= stall_nxt_s & irq_en_nxt_s;
        end
    end

    assign stall_bit_s = stall_r;
    assign irq         = irq_r;
`else
    assign stall_hit_s = 1'b0;
    assign stall_bit_s = 1'b0;
    assign irq         = 1'b0;
`endif

    // Next-state logic: clearing AUTO dominates, then spin-up entry, then normal sequencing.
    always_comb begin
        state_nxt_s = state_r;
        if (auto_clr_s) begin
            state_nxt_s = ST_IDLE;
        end else if (auto_rise_s || stall_hit_s) begin
            state_nxt_s = ST_SPINUP;
        end else begin
            case (state_r)
                ST_IDLE:   state_nxt_s = (win_ce && auto_r) ? ST_ADJUST : ST_IDLE;
                ST_SPINUP: state_nxt_s = (spin_r == 2'd0) ? ST_IDLE : ST_SPINUP;
                ST_ADJUST: state_nxt_s = ST_IDLE;
                default:   state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Duty source priority: forced full speed, loop adjustment, then manual write in AUTO=0.
    always_comb begin
        duty_nxt_s = duty_r;
        if (auto_rise_s || stall_hit_s) begin
            duty_nxt_s = 8'hFF;
        end else if (adjust_s) begin
            duty_nxt_s = adj_duty(duty_r, target_r, tach_s);
        end else if (wr_duty_s && !auto_r) begin
            duty_nxt_s = csr_di;
        end else begin
            duty_nxt_s = duty_r;
        end
    end

    // CSR read multiplexer, zero when the address is outside this block.
    always_comb begin
        rd_data_s = 8'h00;
        if (hit_s) begin
            case (off_s[1:0])
                REG_CTRL:   rd_data_s = {stall_bit_s, 4'b0000, irq_en_r, auto_r, en_r};
                REG_TARGET: rd_data_s = target_r;
                REG_TACH:   rd_data_s = tach_s;
                REG_DUTY:   rd_data_s = duty_r;
                default:    rd_data_s = 8'h00;
            endcase
        end else begin
            rd_data_s = 8'h00;
        end
    end

    // Control/state registers, spin-up window counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_r     <= 1'b0;
            auto_r   <= 1'b0;
            irq_en_r <= 1'b0;
            target_r <= 8'd0;
            duty_r   <= 8'd0;
            spin_r   <= 2'd0;
            csr_do_r <= 8'd0;
            state_r  <= ST_IDLE;
        end else begin
            if (wr_ctrl_s) begin
                en_r     <= csr_di[CTRL_EN_BIT];
                auto_r   <= csr_di[CTRL_AUTO_BIT];
                irq_en_r <= csr_di[CTRL_IRQ_EN_BIT];
            end
            if (wr_target_s) begin
                target_r <= csr_di;
            end
            if (auto_rise_s || stall_hit_s) begin
                spin_r <= SPINUP_WIN;
            end else if ((state_r == ST_SPINUP) && win_ce && (spin_r != 2'd0)) begin
                spin_r <= spin_r - 2'd1;
            end
            duty_r   <= duty_nxt_s;
            csr_do_r <= rd_data_s;
            state_r  <= state_nxt_s;
        end
    end

    assign csr_do   = csr_do_r;
    assign pwm_duty = duty_r;
    assign pwm_en   = en_r;

endmodule

// File: tb/tb_fan_ctrl.sv
// Scoreboard bench for fan_ctrl: directed stimulus pushes expectations, a negedge monitor checks them.
module tb_fan_ctrl;

    localparam logic [4:0] A_CTRL   = 5'h18;
    localparam logic [4:0] A_TARGET = 5'h19;
    localparam logic [4:0] A_TACH   = 5'h1A;
    localparam logic [4:0] A_DUTY   = 5'h1B;
    localparam logic [1:0] K_RD     = 2'd0;
    localparam logic [1:0] K_DUTY   = 2'd1;
    localparam logic [1:0] K_IRQ    = 2'd2;
    localparam logic [1:0] K_EN     = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       win_ce = 1'b0;
    logic       tach = 1'b0;
    logic [4:0] csr_a = 5'd0;
    logic [7:0] csr_di = 8'd0;
    logic       csr_we = 1'b0;
    logic [7:0] csr_do;
    logic [7:0] pwm_duty;
    logic       pwm_en;
    logic       irq;

    logic [9:0] exp_q[$];
    string      nm_q[$];
    int         req_n = 0;
    int         vld_n = 0;
    logic       done_req = 1'b0;
    logic       done_seen = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         d_exp;

    fan_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .win_ce   (win_ce),
        .tach     (tach),
        .csr_a    (csr_a),
        .csr_di   (csr_di),
        .csr_we   (csr_we),
        .csr_do   (csr_do),
        .pwm_duty (pwm_duty),
        .pwm_en   (pwm_en),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) vld_n <= req_n;

    always @(negedge clk) begin
        logic [9:0] e;
        string      nm;
        logic [7:0] act;
        for (int i = 0; i < vld_n; i++) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: got empty queue required an entry");
            end else begin
                e  = exp_q.pop_front();
                nm = nm_q.pop_front();
                case (e[9:8])
                    K_RD:    act = csr_do;
                    K_DUTY:  act = pwm_duty;
                    K_IRQ:   act = {7'd0, irq};
                    default: act = {7'd0, pwm_en};
                endcase
                if (act !== e[7:0]) begin
                    errors++;
                    $display("FAIL %s: got %0d required %0d", nm, act, e[7:0]);
                end
            end
        end
        if (done_req && !done_seen) begin
            done_seen = 1'b1;
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] k, input int v, input string nm);
        logic [7:0] v8;
        v8 = v[7:0];
        exp_q.push_back({k, v8});
        nm_q.push_back(nm);
    endtask

    task automatic csr_wr(input logic [4:0] a, input logic [7:0] d);
        csr_a = a; csr_di = d; csr_we = 1'b1;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic rd_chk(input logic [4:0] a, input int exp_rd, input int exp_duty, input string nm);
        csr_a = a;
        push(K_RD, exp_rd, {nm, "_rd"});
        push(K_DUTY, exp_duty, {nm, "_duty"});
        req_n = 2;
        tick();
        req_n = 0;
    endtask

    task automatic chk_sig(input logic [1:0] k, input int v, input string nm);
        push(k, v, nm);
        req_n = 1;
        tick();
        req_n = 0;
    endtask

    task automatic tach_edges(input int n);
        repeat (n) begin
            tach = 1'b1; tick(); tick();
            tach = 1'b0; tick(); tick();
        end
        repeat (4) tick();
    endtask

    task automatic win_pulse();
        win_ce = 1'b1;
        tick();
        win_ce = 1'b0;
    endtask

    task automatic win(input int n, input int exp_tach, input int exp_duty, input string nm);
        tach_edges(n);
        win_pulse();
        rd_chk(A_TACH, exp_tach, exp_duty, nm);
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        rd_chk(A_CTRL,   0, 0, "rst_ctrl");
        rd_chk(A_TARGET, 0, 0, "rst_target");
        rd_chk(A_TACH,   0, 0, "rst_tach");
        rd_chk(A_DUTY,   0, 0, "rst_duty");
        chk_sig(K_EN,  0, "rst_pwm_en");
        chk_sig(K_IRQ, 0, "rst_irq");

        csr_wr(A_CTRL, 8'h01);
        chk_sig(K_EN, 1, "pwm_en_set");
        rd_chk(A_CTRL, 1, 0, "ctrl_en");
        csr_wr(A_DUTY, 8'h5a);
        rd_chk(A_DUTY, 8'h5a, 8'h5a, "manual_duty");
        rd_chk(5'h00, 0, 8'h5a, "unmapped_addr");
        csr_wr(A_TARGET, 8'd100);
        rd_chk(A_TARGET, 100, 8'h5a, "target_rw");

        // edge on the strobe cycle: excluded here, first count of the next window
        tach_edges(5);
        tach = 1'b1; tick(); tick();
        win_pulse();
        rd_chk(A_TACH, 5, 8'h5a, "coincident_excl");
        tach = 1'b0; tick(); tick();
        win(3, 4, 8'h5a, "coincident_next");

        csr_wr(A_TARGET, 8'd0);
        csr_wr(A_CTRL, 8'h03);
        rd_chk(A_CTRL, 3, 255, "auto_spinup");
        csr_wr(A_DUTY, 8'h10);
        rd_chk(A_DUTY, 255, 255, "duty_wr_ignored");
        win(20, 20, 255, "spinup_win1");
        win(20, 20, 255, "spinup_win2");

        csr_wr(A_TARGET, 8'd100);
        win(50,  50,  255, "adj_up_clamp");
        win(120, 120, 247, "adj_down_big");
        win(105, 105, 246, "adj_down_small");
        win(95,  95,  247, "adj_up_small");
        win(300, 255, 239, "tach_saturate");

        csr_wr(A_TARGET, 8'd0);
        d_exp = 239;
        for (int i = 0; i < 26; i++) begin
            d_exp = (d_exp - 8 < 40) ? 40 : d_exp - 8;
            win(20, 20, d_exp, "ramp_to_min");
        end
        csr_wr(A_TARGET, 8'd20);
        win(20, 20, 40, "err_zero");

        csr_wr(A_TARGET, 8'd100);
        tach_edges(20);
        win_pulse();
        csr_wr(A_DUTY, 8'h10);
        chk_sig(K_DUTY, 48, "adjust_beats_wr");

        tach_edges(20);
        win_pulse();
        csr_wr(A_CTRL, 8'h01);
        chk_sig(K_DUTY, 48, "auto_clr_hold");
        rd_chk(A_CTRL, 1, 48, "auto_clr_ctrl");
        win(20, 20, 48, "auto_off_no_adj");
        csr_wr(A_DUTY, 8'h33);
        rd_chk(A_DUTY, 8'h33, 8'h33, "manual_after_auto");

`ifdef FAN_CTRL_STALL_EN
        csr_wr(A_TARGET, 8'd0);
        csr_wr(A_CTRL, 8'h07);
        win(0, 0, 255, "stall_spin1");
        win(0, 0, 255, "stall_spin2");
        win(20, 20, 247, "stall_pre1");
        win(20, 20, 239, "stall_pre2");
        win(0, 0, 239, "stall_zero1");
        chk_sig(K_IRQ, 0, "stall_irq_pending");
        win(0, 0, 239, "stall_zero2");
        win(0, 0, 255, "stall_force");
        chk_sig(K_IRQ, 1, "stall_irq");
        rd_chk(A_CTRL, 8'h87, 255, "stall_flag");
        csr_wr(A_CTRL, 8'h87);
        rd_chk(A_CTRL, 8'h07, 255, "stall_w1c");
        chk_sig(K_IRQ, 0, "stall_irq_clr");
`else
        chk_sig(K_IRQ, 0, "irq_tied_low");
`endif

        repeat (3) tick();
        done_req = 1'b1;
        repeat (3) tick();
        $display("FAIL monitor_end: got no summary required summary");
        $fatal(1);
    end

endmodule
